down_counter_reload: RTL and testbench

Parameterised loadable down-counter with terminal-count detection and optional auto-reload. It is the counting-down counterpart of the team's 4-bit up counter. It serves as the interval/timeout timer for blocks that need "N enabled cycles elapsed" events. It sits beside the up counter in the counter library and shares its clock domain.

---
 rtl/down_counter_reload.sv | 95 +++++++++
 tb/tb_down_counter_reload.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/down_counter_reload.sv
// Loadable WIDTH-bit down-counter with terminal-count pulse and optional auto-reload.
// Interval/timeout timer: signals "N enabled cycles elapsed" via tc_pulse.
module down_counter_reload #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] cnt,
  output logic             zero,
  output logic             tc_pulse,
  output logic             busy
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rld_q, rld_d;
  logic             tc_q, tc_d;

  // Next-state: load beats counting; reaching 1 is the terminal cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rld_d   = rld_q;
    tc_d    = 1'b0;
    if (load) begin
      cnt_d = load_val;
      rld_d = load_val;
      if (load_val != CNT_ZERO) begin
        state_d = RUN;
      end else begin
        state_d = IDLE;
      end
    end else begin
      case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        RUN: begin
          if (en) begin
            if (cnt_q == CNT_ONE) begin
              tc_d = 1'b1;
              if (auto_reload) begin
                cnt_d = rld_q;
              end else begin
                cnt_d   = CNT_ZERO;
                state_d = IDLE;
              end
            end else begin
              cnt_d = cnt_q - CNT_ONE;
            end
          end else begin
            cnt_d = cnt_q;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = CNT_ZERO;
        end
      endcase
    end
  end

  // State, count, reload and pulse registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= CNT_ZERO;
      rld_q   <= CNT_ZERO;
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rld_q   <= rld_d;
      tc_q    <= tc_d;
    end
  end

  assign cnt      = cnt_q;
  assign zero     = (cnt_q == CNT_ZERO);
  assign tc_pulse = tc_q;
  assign busy     = (state_q == RUN);

endmodule

// File: tb/tb_down_counter_reload.sv
// Directed and randomized bench for down_counter_reload against an arithmetic reference model.
module tb_down_counter_reload;

  logic       clk;
  logic       rst;
  logic       load;
  logic [3:0] load_val;
  logic       en;
  logic       auto_reload;
  logic [3:0] cnt;
  logic       zero;
  logic       tc_pulse;
  logic       busy;

  int n_cmp;
  int n_mis;

  // Reference: remaining count and period; a non-zero count means the timer is running.
  int m_cnt;
  int m_rld;
  int m_tc;

  down_counter_reload #(.WIDTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .load_val   (load_val),
    .en         (en),
    .auto_reload(auto_reload),
    .cnt        (cnt),
    .zero       (zero),
    .tc_pulse   (tc_pulse),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic ld, input int v, input logic e, input logic ar);
    rst         = r;
    load        = ld;
    load_val    = 4'(v);
    en          = e;
    auto_reload = ar;
    @(posedge clk);
    if (r) begin
      m_cnt = 0; m_rld = 0; m_tc = 0;
    end else if (ld) begin
      m_cnt = v; m_rld = v; m_tc = 0;
    end else if (e && m_cnt != 0) begin
      if (m_cnt == 1) begin
        m_tc  = 1;
        m_cnt = ar ? m_rld : 0;
      end else begin
        m_tc  = 0;
        m_cnt = m_cnt - 1;
      end
    end else begin
      m_tc = 0;
    end
    #1;
    check("cnt",      int'(cnt),      m_cnt);
    check("zero",     int'(zero),     (m_cnt == 0) ? 1 : 0);
    check("busy",     int'(busy),     (m_cnt != 0) ? 1 : 0);
    check("tc_pulse", int'(tc_pulse), m_tc);
  endtask

  initial begin
    int tc_seen;
    int tc_at;
    n_cmp = 0; n_mis = 0;
    m_cnt = 0; m_rld = 0; m_tc = 0;
    rst = 1'b1; load = 1'b0; load_val = 4'd0; en = 1'b0; auto_reload = 1'b0;

    // Reset overrides a simultaneous load.
    step(1'b1, 1'b1, 9, 1'b1, 1'b0);
    step(1'b1, 1'b1, 9, 1'b1, 1'b0);
    check("reset_cnt", int'(cnt), 0);

    // One-shot from 5, then 10 idle cycles with en held high.
    step(1'b0, 1'b1, 5, 1'b0, 1'b0);
    tc_seen = 0;
    for (int i = 0; i < 15; i++) begin
      step(1'b0, 1'b0, 0, 1'b1, 1'b0);
      tc_seen += int'(tc_pulse);
    end
    check("oneshot_tc_count", tc_seen, 1);

    // Auto-reload from 3, then period 1.
    step(1'b0, 1'b1, 3, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1, 1'b0, 1'b1);
    tc_seen = 0;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 0, 1'b1, 1'b1);
      tc_seen += int'(tc_pulse);
    end
    check("period1_tc_count", tc_seen, 4);

    // Enable gaps.
    step(1'b0, 1'b1, 4, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 0, ((i % 2) == 0) ? 1'b1 : 1'b0, 1'b0);
    check("gaps_final_cnt", int'(cnt), 0);

    // Load collides with terminal cycle; then load 0 aborts a run.
    step(1'b0, 1'b1, 2, 1'b0, 1'b0);
    step(1'b0, 1'b0, 0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 9, 1'b1, 1'b1);
    check("collide_cnt", int'(cnt), 9);
    step(1'b0, 1'b0, 0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 0, 1'b1, 1'b1);
    check("load0_busy", int'(busy), 0);

    // Maximum period: tc exactly 15 enabled cycles after the load.
    step(1'b0, 1'b1, 15, 1'b0, 1'b0);
    tc_at = -1;
    for (int i = 1; i <= 20; i++) begin
      step(1'b0, 1'b0, 0, 1'b1, 1'b0);
      if (tc_pulse === 1'b1 && tc_at < 0) tc_at = i;
    end
    check("max_period_tc_at", tc_at, 15);

    // Reset mid-count, then en without load must not move cnt.
    step(1'b0, 1'b1, 10, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 0, 1'b1, 1'b0);
    check("pre_abort_cnt", int'(cnt), 7);
    step(1'b1, 1'b0, 0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 0, 1'b1, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0,
           int'($urandom_range(0, 15)),
           ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
           1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
